// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the execute stage: fixed-latency MULT/MULTU, radix-2 restoring
// DIV/DIVU (one quotient bit per cycle), and single-cycle MTHI/MTLO.
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DFIX = 2'd3
  } state_t;
endpackage

// Handshake: a request is taken on a rising edge where req_valid & req_ready & ~flush.
// req_ready is high only in IDLE; upstream holds req_* stable until it is taken.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  op_t         req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output state_t      dbg_state
);

  localparam logic [4:0] MUL_CNT = 5'(MUL_CYCLES - 1);

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [63:0] prod, prod_n;
  logic [31:0] rem, rem_n;
  logic [31:0] quo, quo_n;
  logic [31:0] dvs, dvs_n;
  logic        qneg, qneg_n;
  logic        rneg, rneg_n;
  logic [31:0] hi_n, lo_n;
  logic        done_n;
  logic        busy_n;

  logic        accept;
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, rem_sub;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready & ~flush;
  assign dbg_state = state;

  // Low 64 bits of the 64x64 product equal the exact 32x32 product for both signednesses.
  assign a_sx   = {{32{req_a[31]}}, req_a};
  assign b_sx   = {{32{req_b[31]}}, req_b};
  assign a_zx   = {32'd0, req_a};
  assign b_zx   = {32'd0, req_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign a_abs = req_a[31] ? (~req_a + 32'd1) : req_a;
  assign b_abs = req_b[31] ? (~req_b + 32'd1) : req_b;

  // Shifted remainder needs 33 bits: it can exceed 2^32-1 before the subtract.
  assign rem_sh  = {rem, quo[31]};
  assign rem_sub = rem_sh - {1'b0, dvs};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    prod_n  = prod;
    rem_n   = rem;
    quo_n   = quo;
    dvs_n   = dvs;
    qneg_n  = qneg;
    rneg_n  = rneg;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MTHI: hi_n = req_a;
            OP_MTLO: lo_n = req_a;
            OP_MULT, OP_MULTU: begin
              prod_n = (req_op == OP_MULT) ? prod_s : prod_u;
              if (MUL_CYCLES == 1) begin
                {hi_n, lo_n} = prod_n;
                done_n       = 1'b1;
              end else begin
                cnt_n   = MUL_CNT;
                state_n = ST_MUL;
              end
            end
            OP_DIV: begin
              dvs_n   = b_abs;
              quo_n   = a_abs;
              rem_n   = 32'd0;
              qneg_n  = req_a[31] ^ req_b[31];
              rneg_n  = req_a[31];
              cnt_n   = 5'd31;
              state_n = ST_DIV;
            end
            OP_DIVU: begin
              dvs_n   = req_b;
              quo_n   = req_a;
              rem_n   = 32'd0;
              qneg_n  = 1'b0;
              rneg_n  = 1'b0;
              cnt_n   = 5'd31;
              state_n = ST_DIV;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt == 5'd0) begin
          {hi_n, lo_n} = prod;
          done_n       = 1'b1;
          state_n      = ST_IDLE;
        end else begin
          cnt_n = cnt - 5'd1;
        end
      end
      ST_DIV: begin
        // A zero divisor always subtracts, giving quo=all-ones and rem=dividend.
        if (rem_sh >= {1'b0, dvs}) begin
          rem_n = rem_sub[31:0];
          quo_n = {quo[30:0], 1'b1};
        end else begin
          rem_n = rem_sh[31:0];
          quo_n = {quo[30:0], 1'b0};
        end
        if (cnt == 5'd0) state_n = ST_DFIX;
        else             cnt_n   = cnt - 5'd1;
      end
      ST_DFIX: begin
        lo_n    = qneg ? (~quo + 32'd1) : quo;
        hi_n    = rneg ? (~rem + 32'd1) : rem;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (flush) begin
      state_n = ST_IDLE;
      hi_n    = hi;
      lo_n    = lo;
      done_n  = 1'b0;
    end
  end

  assign busy_n = (state_n != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
      prod  <= 64'd0;
      rem   <= 32'd0;
      quo   <= 32'd0;
      dvs   <= 32'd0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prod  <= prod_n;
      rem   <= rem_n;
      quo   <= quo_n;
      dvs   <= dvs_n;
      qneg  <= qneg_n;
      rneg  <= rneg_n;
      hi    <= hi_n;
      lo    <= lo_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of HI/LO operations with
// hand-computed results and latencies, plus flush, stall and mid-op reset sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  op_t         req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  state_t      dbg_state;

  int n_vec;
  int n_fail;

  typedef struct {
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;   // 0: no done pulse expected
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer #(.MUL_CYCLES(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && busy && done) begin
      n_fail++;
      $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Presents a request at the negedge; returns #1 after the accepting edge E0.
  task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NONE;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    logic busy_ok;
    string tag;
    tag = $sformatf("vec%0d", idx);
    issue(v.op, v.a, v.b);
    if (v.exp_lat == 0) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
    end else begin
      lat     = 0;
      busy_ok = 1'b1;
      while (!done && lat < 60) begin
        if (!busy) busy_ok = 1'b0;
        @(posedge clk);
        #1;
        lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    end
    check({tag, "_hi"}, hi, v.exp_hi);
    check({tag, "_lo"}, lo, v.exp_lo);
    if (v.exp_lat != 0) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int   waited;
    logic saw_done;

    n_vec     = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_NONE;
    req_a     = 32'd0;
    req_b     = 32'd0;
    flush     = 1'b0;

    vecs.push_back('{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3});
    vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 3});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vecs.push_back('{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 33});
    vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33});
    vecs.push_back('{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 33});
    vecs.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 3});
    vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3});
    vecs.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33});
    vecs.push_back('{OP_DIV,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 33});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001, 33});
    vecs.push_back('{OP_MTHI,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0001, 0});
    vecs.push_back('{OP_MTLO,  32'h0000_1234, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_1234, 0});
    vecs.push_back('{OP_NONE,  32'h5555_5555, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_1234, 0});

    repeat (2) @(posedge clk);
    #1;
    check("reset_hi",    hi, 32'd0);
    check("reset_lo",    lo, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_done",  {31'd0, done}, 32'd0);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Undefined opcode encoding is ignored.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op_t'(3'd7);
    req_a     = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NONE;
    check("illegal_op_busy", {31'd0, busy}, 32'd0);
    check("illegal_op_hi", hi, 32'hDEAD_BEEF);
    check("illegal_op_lo", lo, 32'h0000_1234);

    // Flush a DIV in flight on its 10th cycle: HI/LO keep pre-DIV values, no done.
    issue(OP_DIV, 32'h0000_0064, 32'h0000_0003);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy",  {31'd0, busy}, 32'd0);
    check("flush_ready", {31'd0, req_ready}, 32'd1);
    check("flush_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("flush_hi", hi, 32'hDEAD_BEEF);
    check("flush_lo", lo, 32'h0000_1234);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    check("flush_hi_later", hi, 32'hDEAD_BEEF);

    // A request on a flush edge is not accepted.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    req_a     = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_NONE;
    check("flush_req_hi", hi, 32'hDEAD_BEEF);
    check("flush_req_busy", {31'd0, busy}, 32'd0);

    // MTHI held while MULTU 3*4 is busy: stalled three cycles, then accepted.
    issue(OP_MULTU, 32'd3, 32'd4);
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    req_a     = 32'hAAAA_5555;
    while (!req_ready && waited < 60) begin
      check($sformatf("stall_hi_%0d", waited), hi, 32'hDEAD_BEEF);
      waited++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(waited), 32'd3);
    check("stall_hi_after_mul", hi, 32'h0000_0000);
    check("stall_lo_after_mul", lo, 32'h0000_000C);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NONE;
    check("stall_mthi_hi", hi, 32'hAAAA_5555);
    check("stall_mthi_lo", lo, 32'h0000_000C);
    check("stall_mthi_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a DIV, then a normal MULT.
    issue(OP_DIVU, 32'h0000_1000, 32'h0000_0010);
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_hi",   hi, 32'd0);
    check("midreset_lo",   lo, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_vec('{OP_MULT, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3}, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
